// File: rtl/latch_bank_write_arb.sv
// Two-requester round-robin write arbiter for a bank of gated SR latches.
// Each write drives a setup / gate-pulse / hold waveform, then checks readback.
module latch_bank_write_arb #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [7:0]       err_count,
  output logic             busy,
  output logic [WIDTH-1:0] latch_R,
  output logic [WIDTH-1:0] latch_S,
  output logic             latch_G,
  input  logic [WIDTH-1:0] latch_Q
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] wdata;
  logic             owner;   // requester currently being served
  logic             rr_ptr;  // 1: requester 1 wins the next contended grant
  logic             pick;
  logic [WIDTH-1:0] pick_data;

  always_comb begin
    pick      = req1 & (~req0 | rr_ptr);
    pick_data = pick ? data1 : data0;
  end

  // Outputs are loaded on the edge entering each state, so they line up with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata     <= '0;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
      latch_R   <= '0;
      latch_S   <= '0;
      latch_G   <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner   <= pick;
            rr_ptr  <= ~pick;
            gnt0    <= ~pick;
            gnt1    <= pick;
            wdata   <= pick_data;
            latch_S <= pick_data;
            latch_R <= ~pick_data;
            latch_G <= 1'b0;
            cnt     <= CW'(SETUP_CYC - 1);
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            latch_G <= 1'b1;
            cnt     <= CW'(PULSE_CYC - 1);
            state   <= PULSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            latch_G <= 1'b0;
            cnt     <= CW'(HOLD_CYC - 1);
            state   <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            latch_R <= '0;
            latch_S <= '0;
            state   <= CHECK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CHECK: begin
          err <= (latch_Q != wdata);
          if ((latch_Q != wdata) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
          done0 <= ~owner;
          done1 <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_write_arb.sv
// Directed bench for latch_bank_write_arb: default instance plus a
// SETUP=3/PULSE=1/HOLD=2 instance, each driving a behavioural latch bank.
module tb_latch_bank_write_arb;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       gnt0, gnt1, done0, done1, err, busy, latch_G;
  logic [7:0] err_count, latch_R, latch_S, latch_Q;
  logic [7:0] bank = '0;
  logic       fault = 1'b0;

  logic       s_req0 = 1'b0;
  logic [7:0] s_data0 = '0;
  logic       s_gnt0, s_gnt1, s_done0, s_done1, s_err, s_busy, s_G;
  logic [7:0] s_err_count, s_R, s_S, s_Q;
  logic [7:0] s_bank = '0;

  int n_cmp = 0;
  int n_err = 0;
  int gc, dc, ndone, bad, gcount;
  int gseq[$];

  always #5 Clk = ~Clk;

  latch_bank_write_arb u_dut (
    .Clk(Clk), .Reset(Reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .err_count(err_count), .busy(busy), .latch_R(latch_R), .latch_S(latch_S),
    .latch_G(latch_G), .latch_Q(latch_Q)
  );

  latch_bank_write_arb #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_sweep (
    .Clk(Clk), .Reset(Reset), .req0(s_req0), .data0(s_data0), .req1(1'b0), .data1(8'h00),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .done0(s_done0), .done1(s_done1), .err(s_err),
    .err_count(s_err_count), .busy(s_busy), .latch_R(s_R), .latch_S(s_S),
    .latch_G(s_G), .latch_Q(s_Q)
  );

  // Latch bank model: bits follow S/R while the gate is open; optional bit 3 stuck at 0.
  always @(posedge Clk) begin
    if (latch_G) bank <= (bank & ~latch_R) | latch_S;
    if (s_G)     s_bank <= (s_bank & ~s_R) | s_S;
  end
  assign latch_Q = bank & (fault ? 8'hF7 : 8'hFF);
  assign s_Q     = s_bank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      chk("inv_rs_overlap", {24'd0, latch_R & latch_S}, 32'd0);
      chk("inv_gnt_both", {31'd0, gnt0 & gnt1}, 32'd0);
      if (!busy) chk("inv_idle_lines", {15'd0, latch_G, latch_R, latch_S}, 32'd0);
      if (latch_G) chk("inv_gate_rs", {23'd0, busy, latch_R ^ latch_S}, 32'h1FF);
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input bit which, input logic [7:0] d, output int g, output int dn);
    g = 0;
    dn = 0;
    if (which) begin req1 = 1'b1; data1 = d; end
    else       begin req0 = 1'b1; data0 = d; end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (which ? gnt1 : gnt0) g = c;
      if (which ? done1 : done0) begin
        dn = c;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (dn == 0) chk("write_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tick();
    tick();
    chk("reset_state", {gnt0, gnt1, done0, done1, err, busy, latch_G, err_count, latch_R, latch_S}, 32'd0);
    Reset = 1'b0;

    // Single write from requester 0, cycle by cycle.
    req0 = 1'b1;
    data0 = 8'hA5;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        chk("single_gnt0", {31'd0, gnt0}, 32'd1);
        data0 = 8'h00;
      end
      chk("single_S", {24'd0, latch_S}, (c <= 4) ? 32'hA5 : 32'h00);
      chk("single_R", {24'd0, latch_R}, (c <= 4) ? 32'h5A : 32'h00);
      chk("single_G", {31'd0, latch_G}, (c == 2 || c == 3) ? 32'd1 : 32'd0);
      chk("single_busy", {31'd0, busy}, (c <= 5) ? 32'd1 : 32'd0);
      chk("single_done0", {31'd0, done0}, (c == 6) ? 32'd1 : 32'd0);
    end
    req0 = 1'b0;
    chk("single_err", {31'd0, err}, 32'd0);
    chk("single_bank", {24'd0, latch_Q}, 32'hA5);
    tick();
    chk("single_no_regrant", {30'd0, gnt0, busy}, 32'd0);

    // Contention from reset: grants alternate 0, 1, 0.
    Reset = 1'b1;
    req0 = 1'b1; data0 = 8'h0F;
    req1 = 1'b1; data1 = 8'hF0;
    tick();
    Reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60 && ndone < 3; c++) begin
      tick();
      if (gnt0) gseq.push_back(0);
      if (gnt1) gseq.push_back(1);
      if (done0 || done1) begin
        ndone++;
        chk("cont_bank", {24'd0, latch_Q}, done0 ? 32'h0F : 32'hF0);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("cont_ndone", ndone, 3);
    chk("cont_ngnt", gseq.size(), 3);
    chk("cont_g0", (gseq.size() > 0) ? gseq[0] : 9, 0);
    chk("cont_g1", (gseq.size() > 1) ? gseq[1] : 9, 1);
    chk("cont_g2", (gseq.size() > 2) ? gseq[2] : 9, 0);

    // Readback fault: bit 3 stuck at 0.
    fault = 1'b1;
    do_write(1'b1, 8'hFF, gc, dc);
    chk("fault_done_cyc", dc, 6);
    chk("fault_err", {31'd0, err}, 32'd1);
    chk("fault_count", {24'd0, err_count}, 32'd1);
    tick();
    do_write(1'b1, 8'h00, gc, dc);
    chk("fault0_err", {31'd0, err}, 32'd0);
    chk("fault0_count", {24'd0, err_count}, 32'd1);
    fault = 1'b0;
    tick();

    // Reset during PULSE aborts the write.
    req1 = 1'b1;
    data1 = 8'h3C;
    tick();
    chk("rst_gnt1", {31'd0, gnt1}, 32'd1);
    tick();
    chk("rst_in_pulse", {31'd0, latch_G}, 32'd1);
    Reset = 1'b1;
    req1 = 1'b0;
    tick();
    chk("rst_outputs", {gnt0, gnt1, done0, done1, err, busy, latch_G, err_count, latch_R, latch_S}, 32'd0);
    Reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done0 || done1 || busy) bad++;
    end
    chk("rst_no_done", bad, 0);
    do_write(1'b1, 8'h3C, gc, dc);
    chk("rst_regrant_cyc", gc, 1);
    chk("rst_redone_cyc", dc, 6);
    chk("rst_re_err", {31'd0, err}, 32'd0);
    tick();

    // Saturation: 260 faulty writes.
    fault = 1'b1;
    for (int n = 0; n < 260; n++) begin
      do_write(1'b0, 8'hFF, gc, dc);
      tick();
    end
    chk("sat_count", {24'd0, err_count}, 32'hFF);
    chk("sat_err", {31'd0, err}, 32'd1);

    // Request dropped one cycle after its grant still completes.
    req0 = 1'b1;
    data0 = 8'h5A;
    tick();
    chk("drop_gnt0", {31'd0, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    dc = 0;
    for (int c = 3; c <= 20; c++) begin
      tick();
      if (done0) begin
        dc = c;
        break;
      end
    end
    chk("drop_done_cyc", dc, 6);
    chk("drop_count", {24'd0, err_count}, 32'hFF);
    fault = 1'b0;
    tick();

    // Parameter sweep instance: gate for exactly 1 cycle, 8 cycles to done.
    s_req0 = 1'b1;
    s_data0 = 8'hC3;
    gcount = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) chk("sweep_gnt0", {31'd0, s_gnt0}, 32'd1);
      if (s_G) gcount++;
      chk("sweep_G", {31'd0, s_G}, (c == 4) ? 32'd1 : 32'd0);
      chk("sweep_done0", {31'd0, s_done0}, (c == 8) ? 32'd1 : 32'd0);
      chk("sweep_rs", {24'd0, s_R & s_S}, 32'd0);
    end
    s_req0 = 1'b0;
    chk("sweep_gate_cycles", gcount, 1);
    chk("sweep_err", {31'd0, s_err}, 32'd0);
    chk("sweep_bank", {24'd0, s_Q}, 32'hC3);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
